display_scan_driver: RTL and testbench
======================================

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (legal range >= 2).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port DIGITS_IN  input  16  four 4-bit digit values; digit i = bits [4i+3:4i], digit 0 rightmost.
REQ-005 SHALL have port DOTS_IN  input  4  decimal-point request per digit, bit i = digit i, 1 = lit.
REQ-006 SHALL have port LOAD_IN  input  1  capture strobe for DIGITS_IN/DOTS_IN, sampled every rising edge.
REQ-007 SHALL have port BLANK_LZ_IN  input  1  leading-zero blanking enable, level-sensitive.
REQ-008 SHALL have port SEG_SELECT_OUT  output  2  index of the digit currently driven (0..3).
REQ-009 SHALL have port BIN_OUT  output  4  value of the digit currently driven.
REQ-010 SHALL have port DOT_OUT  output  1  dot request of the digit currently driven, 1 = lit.
REQ-011 SHALL have port BLANK_OUT  output  1  1 = current digit blanked; the top level forces all segments off.
REQ-012 SHALL have port FRAME_OUT  output  1  one-cycle pulse at each frame boundary.
REQ-013 SHALL have port PENDING_OUT  output  1  1 = captured value waiting for the next frame boundary.

Function
REQ-014 SHALL implement a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; tick = cycle in which the count equals REFRESH_DIV-1.
REQ-015 SHALL advance the 2-bit digit index on each tick: 0->1->2->3->0, no other transitions.
REQ-016 SHALL define the frame boundary as a tick while the index equals 3; FRAME_OUT SHALL be 1 in the cycle following that edge only.
REQ-017 SHALL capture DIGITS_IN/DOTS_IN into a shadow register and set pending on each edge with LOAD_IN=1; a later load overwrites the shadow (last wins).
REQ-018 SHALL copy the shadow into the display register only on the frame-boundary edge, then clear pending; no mid-frame update of the display register (no tearing).
REQ-019 SHALL, when LOAD_IN=1 on a frame-boundary edge, transfer DIGITS_IN/DOTS_IN directly into the display register and leave pending cleared.
REQ-020 SHALL, on a frame boundary with pending=0, leave the display register unchanged.
REQ-021 SHALL drive SEG_SELECT_OUT = index, BIN_OUT = display digit[index], DOT_OUT = display dot[index], all from registered state with no combinational path from any input port except BLANK_LZ_IN.
REQ-022 SHALL blank digit i (i = 3, 2, 1) when BLANK_LZ_IN=1, display digits i..3 are all zero, and dot i is 0; digit 0 is never blanked.
REQ-023 SHALL, for a blanked digit, drive BLANK_OUT=1, BIN_OUT=0, DOT_OUT=0; otherwise BLANK_OUT=0.
REQ-024 SHALL make output changes visible in the cycle after the causing edge; latency from LOAD_IN to display = up to the next frame boundary, i.e. at most 4*REFRESH_DIV cycles.
REQ-025 SHALL size the prescaler as the smallest width holding REFRESH_DIV-1; no overflow or skipped ticks.

Reset
REQ-026 SHALL, while RESET=1, immediately and regardless of CLK clear the prescaler, index, shadow, display register and pending.
REQ-027 SHALL hold SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, BLANK_OUT=0, FRAME_OUT=0, PENDING_OUT=0 during reset.
REQ-028 SHALL discard any pending capture on mid-frame reset; first tick after release occurs REFRESH_DIV cycles after the first active edge.
REQ-029 SHALL ignore LOAD_IN on any edge where RESET=1.

Verification
REQ-030 Scan: REFRESH_DIV=4, load 16'h1234 at reset release -> after first frame boundary SEG_SELECT_OUT 0,1,2,3 each for 4 cycles with BIN_OUT 4,3,2,1; FRAME_OUT single pulse every 16 cycles.
REQ-031 Deferred load: load 16'hABCD mid-frame -> PENDING_OUT=1 immediately, BIN_OUT keeps old values until frame boundary, then shows D,C,B,A; PENDING_OUT=0.
REQ-032 Collision: two loads (16'h1111 then 16'h2222) in one frame, then LOAD_IN=1 with 16'h3333 on the boundary edge -> next frame shows 3,3,3,3, PENDING_OUT=0.
REQ-033 Blanking: BLANK_LZ_IN=1, display 16'h0050 DOTS_IN=4'b0000 -> BLANK_OUT=1 on digits 3,2, 0 on digits 1,0; DOTS_IN=4'b1000 -> digit 3 unblanked, DOT_OUT=1; 16'h0000 -> only digit 0 unblanked.
REQ-034 Reset mid-operation: assert RESET between clock edges with PENDING_OUT=1 -> all outputs 0 immediately; after release BIN_OUT=0, first tick after exactly REFRESH_DIV cycles.

Source files
------------

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : display_scan_driver
// Purpose : Four-digit multiplexed display scanner with frame-synchronous,
//           tear-free value updates and leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
module display_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DIGITS_IN,
    input  logic [3:0]  DOTS_IN,
    input  logic        LOAD_IN,
    input  logic        BLANK_LZ_IN,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        BLANK_OUT,
    output logic        FRAME_OUT,
    output logic        PENDING_OUT
);

    localparam int C_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(REFRESH_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [15:0]        r_shadow_digits;
    logic [3:0]         r_shadow_dots;
    logic [15:0]        r_disp_digits;
    logic [3:0]         r_disp_dots;
    logic               r_pending;
    logic               r_frame;

    logic               w_tick;
    logic               w_frame_edge;
    logic [3:0]         w_lz_blank;
    logic [3:0]         w_cur_digit;
    logic               w_cur_dot;
    logic               w_cur_blank;

    assign w_tick       = (r_cnt == C_CNT_MAX);
    assign w_frame_edge = w_tick && (r_idx == 2'd3);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_frame_edge;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
        end
    end

    // The shadow always follows the latest load; pending only survives when
    // the load did not coincide with a frame boundary.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_shadow_digits <= 16'h0000;
            r_shadow_dots   <= 4'h0;
            r_pending       <= 1'b0;
        end else begin
            if (LOAD_IN) begin
                r_shadow_digits <= DIGITS_IN;
                r_shadow_dots   <= DOTS_IN;
            end
            if (w_frame_edge) begin
                r_pending <= 1'b0;
            end else if (LOAD_IN) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_disp_digits <= 16'h0000;
            r_disp_dots   <= 4'h0;
        end else if (w_frame_edge) begin
            if (LOAD_IN) begin
                r_disp_digits <= DIGITS_IN;
                r_disp_dots   <= DOTS_IN;
            end else if (r_pending) begin
                r_disp_digits <= r_shadow_digits;
                r_disp_dots   <= r_shadow_dots;
            end
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero
    // and it carries no decimal point; the rightmost digit always shows.
    assign w_lz_blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz_blank
            assign w_lz_blank[gi] = BLANK_LZ_IN
                                 && (r_disp_digits[15:4*gi] == '0)
                                 && !r_disp_dots[gi];
        end
    endgenerate

    assign w_cur_digit = r_disp_digits[{r_idx, 2'b00} +: 4];
    assign w_cur_dot   = r_disp_dots[r_idx];
    assign w_cur_blank = w_lz_blank[r_idx];

    assign SEG_SELECT_OUT = r_idx;
    assign BIN_OUT        = w_cur_blank ? 4'h0 : w_cur_digit;
    assign DOT_OUT        = w_cur_blank ? 1'b0 : w_cur_dot;
    assign BLANK_OUT      = w_cur_blank;
    assign FRAME_OUT      = r_frame;
    assign PENDING_OUT    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_scan_driver
// Purpose : Self-checking bench for display_scan_driver (directed + random).
// Revision: 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

    localparam int R = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] DIGITS_IN = 16'h0000;
    logic [3:0]  DOTS_IN = 4'h0;
    logic        LOAD_IN = 1'b0;
    logic        BLANK_LZ_IN = 1'b0;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;
    logic        DOT_OUT;
    logic        BLANK_OUT;
    logic        FRAME_OUT;
    logic        PENDING_OUT;

    int checks = 0;
    int errors = 0;

    display_scan_driver #(.REFRESH_DIV(R)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .DIGITS_IN      (DIGITS_IN),
        .DOTS_IN        (DOTS_IN),
        .LOAD_IN        (LOAD_IN),
        .BLANK_LZ_IN    (BLANK_LZ_IN),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .BIN_OUT        (BIN_OUT),
        .DOT_OUT        (DOT_OUT),
        .BLANK_OUT      (BLANK_OUT),
        .FRAME_OUT      (FRAME_OUT),
        .PENDING_OUT    (PENDING_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the scan is derived purely from how many
    // clock edges have elapsed since reset.
    int          m_edges = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [3:0]  m_ddots = 4'h0;
    logic [15:0] m_shadow = 16'h0000;
    logic [3:0]  m_sdots = 4'h0;
    bit          m_pend = 1'b0;
    bit          m_frame = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_edges = 0; m_disp = 0; m_ddots = 0; m_shadow = 0; m_sdots = 0;
            m_pend = 0; m_frame = 0;
        end else begin
            m_frame = ((m_edges % R) == R - 1) && (((m_edges / R) % 4) == 3);
            if (m_frame) begin
                if (LOAD_IN) begin
                    m_disp = DIGITS_IN; m_ddots = DOTS_IN;
                end else if (m_pend) begin
                    m_disp = m_shadow; m_ddots = m_sdots;
                end
                m_pend = 0;
            end else if (LOAD_IN) begin
                m_shadow = DIGITS_IN; m_sdots = DOTS_IN; m_pend = 1;
            end
            m_edges++;
        end
    end

    always begin
        int   idx;
        logic blank;
        @(negedge CLK);
        #1;
        idx   = (m_edges / R) % 4;
        blank = BLANK_LZ_IN && (idx != 0) && ((m_disp >> (4 * idx)) == 0) && !m_ddots[idx];
        check("mdl_seg", SEG_SELECT_OUT, idx);
        check("mdl_bin", BIN_OUT, blank ? 4'h0 : m_disp[4*idx +: 4]);
        check("mdl_dot", DOT_OUT, blank ? 1'b0 : m_ddots[idx]);
        check("mdl_blank", BLANK_OUT, blank);
        check("mdl_frame", FRAME_OUT, m_frame);
        check("mdl_pending", PENDING_OUT, m_pend);
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        DIGITS_IN = v; DOTS_IN = d; LOAD_IN = 1'b1;
        step();
        LOAD_IN = 1'b0;
    endtask

    task automatic wait_frame();
        for (int n = 0; n < 40; n++) begin
            step();
            if (FRAME_OUT) break;
        end
        check("wait_frame", FRAME_OUT, 1'b1);
    endtask

    // Called on the negedge right after a frame boundary; walks one frame.
    task automatic check_frame(input logic [15:0] eb, input logic [3:0] ed, input logic [3:0] ebl);
        LOAD_IN = 1'b0;
        for (int k = 0; k < 16; k++) begin
            int d;
            d = k / 4;
            if (k != 0) step();
            check("cf_seg", SEG_SELECT_OUT, d);
            check("cf_bin", BIN_OUT, eb[4*d +: 4]);
            check("cf_dot", DOT_OUT, ed[d]);
            check("cf_blank", BLANK_OUT, ebl[d]);
            check("cf_frame", FRAME_OUT, k == 0);
            check("cf_pending", PENDING_OUT, 1'b0);
        end
    endtask

    initial begin
        repeat (3) step();
        check("rst_seg", SEG_SELECT_OUT, 0);
        check("rst_bin", BIN_OUT, 0);
        check("rst_frame", FRAME_OUT, 0);
        check("rst_pending", PENDING_OUT, 0);

        // Scan order and frame period
        RESET = 1'b0;
        load(16'h1234, 4'h0);
        check("load_pending", PENDING_OUT, 1'b1);
        wait_frame();
        check_frame(16'h1234, 4'h0, 4'h0);
        step();
        check("frame_period", FRAME_OUT, 1'b1);

        // Deferred load holds old digits until the boundary
        step();
        load(16'hABCD, 4'h0);
        check("defer_pending", PENDING_OUT, 1'b1);
        check("defer_old_bin", BIN_OUT, 4'h4);
        wait_frame();
        check_frame(16'hABCD, 4'h0, 4'h0);

        // Collision: later loads win, boundary load goes straight through
        wait_frame();
        load(16'h1111, 4'h0);
        check("coll_pending", PENDING_OUT, 1'b1);
        repeat (3) step();
        load(16'h2222, 4'h0);
        repeat (10) step();
        load(16'h3333, 4'h0);
        check_frame(16'h3333, 4'h0, 4'h0);

        // Leading-zero blanking
        BLANK_LZ_IN = 1'b1;
        load(16'h0050, 4'b0000);
        wait_frame();
        check_frame(16'h0050, 4'b0000, 4'b1100);
        load(16'h0050, 4'b1000);
        wait_frame();
        check_frame(16'h0050, 4'b1000, 4'b0100);
        load(16'h0000, 4'b0000);
        wait_frame();
        check_frame(16'h0000, 4'b0000, 4'b1110);
        BLANK_LZ_IN = 1'b0;

        // Mid-frame reset discards pending capture
        repeat (5) step();
        load(16'h9999, 4'hF);
        check("rst2_pending_before", PENDING_OUT, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check("rst2_seg", SEG_SELECT_OUT, 0);
        check("rst2_bin", BIN_OUT, 0);
        check("rst2_dot", DOT_OUT, 0);
        check("rst2_blank", BLANK_OUT, 0);
        check("rst2_frame", FRAME_OUT, 0);
        check("rst2_pending", PENDING_OUT, 0);
        DIGITS_IN = 16'h7777; LOAD_IN = 1'b1;
        repeat (2) step();
        LOAD_IN = 1'b0; RESET = 1'b0;
        repeat (3) begin
            step();
            check("rel_seg0", SEG_SELECT_OUT, 0);
            check("rel_bin", BIN_OUT, 0);
        end
        step();
        check("rel_first_tick", SEG_SELECT_OUT, 1);
        wait_frame();
        check_frame(16'h0000, 4'h0, 4'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            step();
            if (RESET) begin
                if ($urandom_range(0, 2) == 0) RESET = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                #2 RESET = 1'b1;
            end
            LOAD_IN = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 4; i++)
                DIGITS_IN[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            DOTS_IN = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 49) == 0) BLANK_LZ_IN = ~BLANK_LZ_IN;
        end
        RESET = 1'b0; LOAD_IN = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
